// File: rtl/regf_pkg.sv
// Shared types and default widths for the register-file arbiter.
package regf_pkg;

  localparam int REGF_ADDR_W = 15;
  localparam int REGF_DATA_W = 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } port_st_e;

  function automatic req_id_e other_req(req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regf_arbiter_if.sv
// Requester-side access bundle: request/lock/address/data in, grant and read return out.
interface regf_arbiter_if
  import regf_pkg::*;
#(
  parameter int ADDR_W = REGF_ADDR_W,
  parameter int DATA_W = REGF_DATA_W
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/regf_port_arb.sv
// Two-requester arbiter for one register-file port, with round-robin and locked bursts.
//
//   state | meaning
//   FREE  | no owner; single candidate wins, contention goes to the pointer holder
//   OWN_A | A holds the port for a locked burst; B is held off
//   OWN_B | B holds the port for a locked burst; A is held off
module regf_port_arb
  import regf_pkg::*;
#(
  parameter int MAX_LOCK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cand,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam int             CNT_W    = $clog2(MAX_LOCK + 1);
  // Counter is cleared on the first beat, so the last allowed beat sees MAX_LOCK-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

  port_st_e          state_q, state_d;
  req_id_e           ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win_vld;
  req_id_e           win_id;

  // Winner selection and next-state for the port.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    win_vld = 1'b0;
    win_id  = REQ_A;
    case (state_q)
      FREE: begin
        if (cand == 2'b11) begin
          win_vld = 1'b1;
          win_id  = ptr_q;
          ptr_d   = other_req(ptr_q);
        end else if (cand[0]) begin
          win_vld = 1'b1;
          win_id  = REQ_A;
        end else if (cand[1]) begin
          win_vld = 1'b1;
          win_id  = REQ_B;
        end
        if (win_vld && lock[win_id] && (MAX_LOCK > 1)) begin
          state_d = (win_id == REQ_A) ? OWN_A : OWN_B;
          cnt_d   = '0;
        end
      end
      OWN_A, OWN_B: begin
        win_id  = (state_q == OWN_A) ? REQ_A : REQ_B;
        win_vld = cand[win_id];
        if (win_vld) cnt_d = cnt_q + CNT_W'(1);
        if (!win_vld || !lock[win_id] || (cnt_d == CNT_LAST)) begin
          state_d = FREE;
          ptr_d   = other_req(win_id);
        end
      end
      default: state_d = FREE;
    endcase
    gnt = {2{reset & win_vld}} & {win_id == REQ_B, win_id == REQ_A};
  end

  // Port state, round-robin pointer and lock-length counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FREE;
      ptr_q   <= REQ_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/regf_arbiter.sv
// Shares a 1W/1R register file between requesters A and B with independent port arbitration
// and a tagged, latency-matched read-return path.
module regf_arbiter
  import regf_pkg::*;
#(
  parameter int ADDR_W   = REGF_ADDR_W,
  parameter int DATA_W   = REGF_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  regf_arbiter_if.slave     a_if,
  regf_arbiter_if.slave     b_if,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] data_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] data_out
);

  logic [1:0] cand_w, cand_r, lock_v, gnt_w, gnt_r;

  assign cand_w = {b_if.req &  b_if.we, a_if.req &  a_if.we};
  assign cand_r = {b_if.req & ~b_if.we, a_if.req & ~a_if.we};
  assign lock_v = {b_if.lock, a_if.lock};

  regf_port_arb #(.MAX_LOCK(MAX_LOCK)) u_wr_arb (
    .clk(clk), .reset(reset), .cand(cand_w), .lock(lock_v), .gnt(gnt_w)
  );

  regf_port_arb #(.MAX_LOCK(MAX_LOCK)) u_rd_arb (
    .clk(clk), .reset(reset), .cand(cand_r), .lock(lock_v), .gnt(gnt_r)
  );

  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d, tag_b_q, tag_b_d, tag_fwd_q, tag_fwd_d;
  logic [DATA_W-1:0] tag_dat_q [RD_LAT];
  logic [DATA_W-1:0] tag_dat_d [RD_LAT];
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              fwd_hit, ret_vld, ret_b;
  logic [DATA_W-1:0] ret_data;

  // Register-file drive and grants, steered from the port winners.
  always_comb begin
    wr_en   = |gnt_w;
    wr_addr = '0;
    data_in = '0;
    if (gnt_w[1]) begin
      wr_addr = b_if.addr;
      data_in = b_if.wdata;
    end else if (gnt_w[0]) begin
      wr_addr = a_if.addr;
      data_in = a_if.wdata;
    end
    rd_en   = |gnt_r;
    rd_addr = '0;
    if (gnt_r[1])      rd_addr = b_if.addr;
    else if (gnt_r[0]) rd_addr = a_if.addr;
    a_if.gnt = gnt_w[0] | gnt_r[0];
    b_if.gnt = gnt_w[1] | gnt_r[1];
  end

  // A write and read to the same address in one cycle return the new data, not the stale array value.
  assign fwd_hit = wr_en & rd_en & (wr_addr == rd_addr);

  // Tag pipeline: requester ID and optional forwarded data travel alongside the array read.
  always_comb begin
    tag_vld_d = RD_LAT'({tag_vld_q, rd_en});
    tag_b_d   = RD_LAT'({tag_b_q, gnt_r[1]});
    tag_fwd_d = RD_LAT'({tag_fwd_q, fwd_hit});
    tag_dat_d = tag_dat_q;
    for (int i = RD_LAT - 1; i > 0; i--) tag_dat_d[i] = tag_dat_q[i-1];
    tag_dat_d[0] = data_in;
  end

  // Return steering; the requester not being served keeps its last read data.
  always_comb begin
    ret_vld     = tag_vld_q[RD_LAT-1];
    ret_b       = tag_b_q[RD_LAT-1];
    ret_data    = tag_fwd_q[RD_LAT-1] ? tag_dat_q[RD_LAT-1] : data_out;
    a_if.rvalid = ret_vld & ~ret_b;
    b_if.rvalid = ret_vld &  ret_b;
    a_rdata_d   = (ret_vld & ~ret_b) ? ret_data : a_rdata_q;
    b_rdata_d   = (ret_vld &  ret_b) ? ret_data : b_rdata_q;
    a_if.rdata  = a_rdata_d;
    b_if.rdata  = b_rdata_d;
  end

  // Return-path state; reset flushes reads in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld_q <= '0;
      tag_b_q   <= '0;
      tag_fwd_q <= '0;
      tag_dat_q <= '{default: '0};
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_b_q   <= tag_b_d;
      tag_fwd_q <= tag_fwd_d;
      tag_dat_q <= tag_dat_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

endmodule
